kendall_stream_rank: RTL and testbench
======================================

Name: kendall_stream_rank

Overview:
- Sequential, handshaked counterpart of the combinational four-point Kendall rank block.
- Receives (x,y) points one at a time over a valid/ready stream and buffers four of them.
- Evaluates the six point pairs serially, one pair per cycle, with a single comparator pair.
- Returns the same signed 4-bit Kendall code over a valid/ready result handshake. Sits between the point-producing front end and the rank consumer.

Parameters:
- COORD_W, 4, coordinate width in bits (unsigned).
- N_PTS, 4, points per frame. Fixed at 4: the pair order and the result code are defined only for 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous frame abort. Discards any partial frame or pending result and returns to LOAD.
- pt_valid  in  1  a point is offered.
- pt_ready  out  1  block accepts the point.
- pt_x  in  COORD_W  point x coordinate.
- pt_y  in  COORD_W  point y coordinate.
- res_valid  out  1  kendall output is valid.
- res_ready  in  1  consumer accepts the result.
- kendall  out  4  signed two's-complement code, equal to 4*tau rounded to nearest.
- busy  out  1  high in COMPARE or DONE.

Behaviour:
- Reset values (rst_n low, asynchronous): state=LOAD, point index=0, discord count=0, pair index=0, kendall=4'b0000, res_valid=0, pt_ready=1, busy=0.
- LOAD state:
  - pt_ready=1.
  - Each accepted point (pt_valid&pt_ready) is stored in slot idx, and idx is incremented.
  - Accepting slot 3 moves the block to COMPARE on the same edge and clears the discord count.
- COMPARE state:
  - pt_ready=0, busy=1.
  - Six cycles, pair index 0..5 = (0,1),(0,2),(0,3),(1,2),(1,3),(2,3).
  - gx = (x_a > x_b), gy = (y_a > y_b), unsigned, strict greater-than. Ties give 0.
  - A pair is discordant when gx XOR gy. Add 1 to the 3-bit count per discordant pair (maximum 6, no overflow possible).
  - After pair 5, register kendall from the final count and go to DONE.
- Count-to-code mapping (count d -> kendall):
  - 0 -> 0100
  - 1 -> 0011
  - 2 -> 0001
  - 3 -> 0000
  - 4 -> 1111
  - 5 -> 1101
  - 6 -> 1100
- DONE state:
  - res_valid=1, with kendall held stable until res_ready is sampled high.
  - On res_valid&res_ready: res_valid=0, idx=0, return to LOAD.
  - kendall keeps its last value after the handshake (not cleared).
- Latency: the 4th point is accepted at edge T. Pairs are evaluated on edges T+1..T+6, and res_valid is high after edge T+6. A new frame's first point can be accepted on the cycle after the result handshake.
- Backpressure:
  - pt_ready is low throughout COMPARE and DONE, so points offered then are not consumed.
  - res_ready low stalls DONE indefinitely.
- clr:
  - Has priority over every handshake in the same cycle.
  - Same-cycle pt_valid is not accepted, and a res_ready handshake is not counted.
  - Next state is LOAD, with idx=0, count=0, res_valid=0.
  - kendall is reset to 0.
- Reset mid-operation: any state returns asynchronously to the reset values. Buffered points need no reset, but are never read before being rewritten.
- Outputs pt_ready, res_valid and busy are decoded from registered state only (no combinational path from inputs).

Decomposition:
- Shared package holds:
  - State encoding: LOAD/COMPARE/DONE.
  - The pair-index-to-slot lookup constants (6 entries of two 2-bit slot numbers).
  - The count-to-kendall constant table (7 x 4-bit).
- One sub-module: kendall_pair_disc. Combinational; takes two points and outputs the discordant flag using strict-greater comparators. Reusable by the combinational block.

Test Plan:
- Concordant: points (1,1),(2,2),(3,3),(4,4) -> d=0. kendall=4'b0100 with res_valid exactly 6 cycles after the 4th accept.
- Reversed: (1,4),(2,3),(3,2),(4,1) -> d=6, kendall=4'b1100. Mixed (1,2),(2,1),(3,4),(4,3) -> d=2, kendall=4'b0001.
- Ties: (5,1),(5,2),(5,3),(5,4) -> every gx=0 and gy=0, so d=0 and kendall=4'b0100. Also (0,15),(15,0),(15,0),(0,15) -> d=4, kendall=4'b1111.
- Backpressure: hold res_ready=0 for 5 cycles in DONE with pt_valid=1 -> kendall stable, pt_ready=0, no point consumed. Then res_ready=1 -> one handshake, and the next point is accepted the following cycle.
- clr after 2 points, and again mid-COMPARE -> state LOAD, res_valid stays 0. A following full frame (1,1),(2,2),(3,3),(4,4) gives 4'b0100.
- rst_n pulsed low in the middle of a DONE cycle -> res_valid, kendall and busy drop to 0 immediately (asynchronously) and pt_ready=1; the next frame computes correctly.

Source files
------------

// File: rtl/kendall_stream_rank_pkg.sv
// rtl/kendall_stream_rank_pkg.sv - shared encodings and lookup tables for the streaming Kendall rank block
//
// Contents:
//   - FSM state encoding (LOAD / COMPARE / DONE)
//   - pair-index-to-slot tables for the six pairs of a four-point frame
//   - discord-count-to-Kendall-code table (4*tau rounded, signed 4-bit)
package kendall_stream_rank_pkg;

    localparam logic [1:0] ST_LOAD    = 2'b00;
    localparam logic [1:0] ST_COMPARE = 2'b01;
    localparam logic [1:0] ST_DONE    = 2'b10;

    localparam logic [2:0] LAST_PAIR = 3'd5;

    // Pair p uses slots (a,b); entry p sits at bits [2p+1:2p].
    // Pairs in order: (0,1),(0,2),(0,3),(1,2),(1,3),(2,3).
    localparam logic [11:0] PAIR_A_TBL = {2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    localparam logic [11:0] PAIR_B_TBL = {2'd3, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1};

    // Kendall code for discord count d sits at bits [4d+3:4d], d = 0..6.
    localparam logic [27:0] KCODE_TBL = {4'b1100, 4'b1101, 4'b1111, 4'b0000,
                                         4'b0001, 4'b0011, 4'b0100};

    function automatic logic [1:0] pair_slot_a(input logic [2:0] p);
        int unsigned i;
        i = p;
        if (i > 5) return 2'd0;
        return PAIR_A_TBL[2*i +: 2];
    endfunction

    function automatic logic [1:0] pair_slot_b(input logic [2:0] p);
        int unsigned i;
        i = p;
        if (i > 5) return 2'd0;
        return PAIR_B_TBL[2*i +: 2];
    endfunction

    // A count of 7 cannot arise from six pairs; it maps to 0.
    function automatic logic [3:0] count_to_code(input logic [2:0] d);
        int unsigned i;
        i = d;
        if (i > 6) return 4'b0000;
        return KCODE_TBL[4*i +: 4];
    endfunction

endpackage

// File: rtl/kendall_pair_disc.sv
// rtl/kendall_pair_disc.sv - combinational discordance test for one pair of points
//
// Ports:
//   xa_i, ya_i : first point coordinates (unsigned)
//   xb_i, yb_i : second point coordinates (unsigned)
//   disc_o     : 1 when the pair is discordant (strict greater-than, ties give 0)
module kendall_pair_disc #(
    parameter int COORD_W = 4
) (
    input  logic [COORD_W-1:0] xa_i,
    input  logic [COORD_W-1:0] ya_i,
    input  logic [COORD_W-1:0] xb_i,
    input  logic [COORD_W-1:0] yb_i,
    output logic               disc_o
);

    logic gx;
    logic gy;

    assign gx     = (xa_i > xb_i);
    assign gy     = (ya_i > yb_i);
    assign disc_o = gx ^ gy;

endmodule

// File: rtl/kendall_stream_rank.sv
// rtl/kendall_stream_rank.sv - streaming four-point Kendall rank: buffer points, compare pairs serially, return code
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   clr                   : synchronous frame abort (highest priority)
//   pt_valid/pt_ready     : point input handshake, coordinates pt_x/pt_y
//   res_valid/res_ready   : result handshake, code on kendall (signed 4-bit, 4*tau)
//   busy                  : high while comparing or holding a result
module kendall_stream_rank
    import kendall_stream_rank_pkg::*;
#(
    parameter int COORD_W = 4,
    parameter int N_PTS   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               pt_valid,
    output logic               pt_ready,
    input  logic [COORD_W-1:0] pt_x,
    input  logic [COORD_W-1:0] pt_y,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [3:0]         kendall,
    output logic               busy
);

    localparam logic [1:0] LAST_IDX = 2'(N_PTS - 1);

    logic [1:0]         state_q,   state_d;
    logic [1:0]         idx_q,     idx_d;
    logic [2:0]         cnt_q,     cnt_d;
    logic [2:0]         pair_q,    pair_d;
    logic [3:0]         kendall_q, kendall_d;

    // Point buffer: written only on accept, so it needs no reset.
    logic [COORD_W-1:0] px_q [4];
    logic [COORD_W-1:0] py_q [4];

    logic               accept;
    logic [1:0]         slot_a;
    logic [1:0]         slot_b;
    logic               disc;
    logic [2:0]         cnt_sum;

    // Handshake outputs decode registered state only.
    assign pt_ready  = (state_q == ST_LOAD);
    assign res_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_LOAD);
    assign kendall   = kendall_q;

    assign accept  = pt_valid && pt_ready && !clr;
    assign slot_a  = pair_slot_a(pair_q);
    assign slot_b  = pair_slot_b(pair_q);
    assign cnt_sum = cnt_q + {2'b00, disc};

    kendall_pair_disc #(
        .COORD_W (COORD_W)
    ) u_pair_disc (
        .xa_i   (px_q[slot_a]),
        .ya_i   (py_q[slot_a]),
        .xb_i   (px_q[slot_b]),
        .yb_i   (py_q[slot_b]),
        .disc_o (disc)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        pair_d    = pair_q;
        kendall_d = kendall_q;

        if (clr) begin
            state_d   = ST_LOAD;
            idx_d     = 2'd0;
            cnt_d     = 3'd0;
            pair_d    = 3'd0;
            kendall_d = 4'b0000;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        idx_d = idx_q + 2'd1;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_COMPARE;
                            idx_d   = 2'd0;
                            cnt_d   = 3'd0;
                            pair_d  = 3'd0;
                        end
                    end
                end
                ST_COMPARE: begin
                    cnt_d  = cnt_sum;
                    pair_d = pair_q + 3'd1;
                    if (pair_q == LAST_PAIR) begin
                        // The final pair's flag is folded in here, not a cycle later.
                        kendall_d = count_to_code(cnt_sum);
                        pair_d    = 3'd0;
                        state_d   = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_d = ST_LOAD;
                        idx_d   = 2'd0;
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                    idx_d   = 2'd0;
                    cnt_d   = 3'd0;
                    pair_d  = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_LOAD;
            idx_q     <= 2'd0;
            cnt_q     <= 3'd0;
            pair_q    <= 3'd0;
            kendall_q <= 4'b0000;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pair_q    <= pair_d;
            kendall_q <= kendall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            px_q[idx_q] <= pt_x;
            py_q[idx_q] <= pt_y;
        end
    end

endmodule

// File: tb/tb_kendall_stream_rank.sv
// tb/tb_kendall_stream_rank.sv - scoreboard bench for kendall_stream_rank
module tb_kendall_stream_rank;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       pt_valid;
    logic       pt_ready;
    logic [3:0] pt_x;
    logic [3:0] pt_y;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] kendall;
    logic       busy;

    int checks;
    int errors;
    logic [3:0] exp_q [$];

    kendall_stream_rank #(
        .COORD_W (4),
        .N_PTS   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .pt_valid  (pt_valid),
        .pt_ready  (pt_ready),
        .pt_x      (pt_x),
        .pt_y      (pt_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .kendall   (kendall),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per result handshake.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected none at %0t", kendall, $time);
            end else begin
                check("result", {4'h0, kendall}, {4'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic send_point(input logic [3:0] x, input logic [3:0] y);
        int n;
        pt_x     = x;
        pt_y     = y;
        pt_valid = 1'b1;
        n = 0;
        while (!pt_ready && n < 50) begin
            wait_edge();
            n++;
        end
        if (!pt_ready) check("pt_ready_timeout", 8'd0, 8'd1);
        wait_edge();
        pt_valid = 1'b0;
    endtask

    // Point i is xs[15-4i -: 4], so the literal lists points in order.
    task automatic send_pts(input logic [15:0] xs, input logic [15:0] ys);
        for (int i = 0; i < 4; i++) send_point(xs[15-4*i -: 4], ys[15-4*i -: 4]);
    endtask

    task automatic wait_load();
        int n;
        n = 0;
        while (!(pt_ready && !res_valid) && n < 40) begin
            wait_edge();
            n++;
        end
        if (!(pt_ready && !res_valid)) check("return_to_load_timeout", 8'd0, 8'd1);
    endtask

    task automatic run_frame(input logic [15:0] xs, input logic [15:0] ys,
                             input logic [3:0] exp, input bit chk_lat);
        exp_q.push_back(exp);
        send_pts(xs, ys);
        if (chk_lat) begin
            for (int k = 1; k <= 6; k++) begin
                wait_edge();
                if (k == 5) check("latency_not_early", {7'd0, res_valid}, 8'd0);
                if (k == 6) check("latency_valid_at_6", {7'd0, res_valid}, 8'd1);
            end
        end
        wait_load();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        pt_valid  = 1'b0;
        pt_x      = 4'd0;
        pt_y      = 4'd0;
        res_ready = 1'b1;

        #1;
        check("reset_pt_ready",  {7'd0, pt_ready},  8'd1);
        check("reset_res_valid", {7'd0, res_valid}, 8'd0);
        check("reset_busy",      {7'd0, busy},      8'd0);
        check("reset_kendall",   {4'd0, kendall},   8'd0);
        #16;
        rst_n = 1'b1;
        wait_edge();

        // Concordant, with latency check, then the other mapping points.
        run_frame({4'd1, 4'd2, 4'd3, 4'd4}, {4'd1, 4'd2, 4'd3, 4'd4}, 4'b0100, 1'b1);
        run_frame({4'd1, 4'd2, 4'd3, 4'd4}, {4'd4, 4'd3, 4'd2, 4'd1}, 4'b1100, 1'b1);
        run_frame({4'd1, 4'd2, 4'd3, 4'd4}, {4'd2, 4'd1, 4'd4, 4'd3}, 4'b0001, 1'b0);
        run_frame({4'd1, 4'd2, 4'd3, 4'd4}, {4'd1, 4'd2, 4'd4, 4'd3}, 4'b0011, 1'b0);
        run_frame({4'd1, 4'd2, 4'd3, 4'd4}, {4'd3, 4'd2, 4'd1, 4'd4}, 4'b0000, 1'b0);
        run_frame({4'd1, 4'd2, 4'd3, 4'd4}, {4'd4, 4'd3, 4'd1, 4'd2}, 4'b1101, 1'b0);
        run_frame({4'd5, 4'd5, 4'd5, 4'd5}, {4'd1, 4'd2, 4'd3, 4'd4}, 4'b0100, 1'b0);
        run_frame({4'd0, 4'd15, 4'd15, 4'd0}, {4'd15, 4'd0, 4'd0, 4'd15}, 4'b1111, 1'b0);

        // Backpressure in DONE with a point offered.
        res_ready = 1'b0;
        exp_q.push_back(4'b1100);
        send_pts({4'd1, 4'd2, 4'd3, 4'd4}, {4'd4, 4'd3, 4'd2, 4'd1});
        for (int k = 0; k < 6; k++) wait_edge();
        check("bp_res_valid", {7'd0, res_valid}, 8'd1);
        pt_x     = 4'd1;
        pt_y     = 4'd1;
        pt_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_edge();
            check("bp_kendall_stable", {4'd0, kendall},   {4'd0, 4'b1100});
            check("bp_pt_ready_low",   {7'd0, pt_ready},  8'd0);
            check("bp_res_valid_held", {7'd0, res_valid}, 8'd1);
        end
        res_ready = 1'b1;
        wait_edge();
        check("bp_after_hs_valid", {7'd0, res_valid}, 8'd0);
        check("bp_after_hs_ready", {7'd0, pt_ready},  8'd1);
        check("bp_kendall_kept",   {4'd0, kendall},   {4'd0, 4'b1100});
        wait_edge();
        pt_valid = 1'b0;
        exp_q.push_back(4'b0100);
        send_point(4'd2, 4'd2);
        send_point(4'd3, 4'd3);
        send_point(4'd4, 4'd4);
        wait_load();

        // clr after two points: the partial frame must be forgotten.
        send_point(4'd15, 4'd0);
        send_point(4'd0, 4'd15);
        clr = 1'b1;
        pt_x = 4'd7;
        pt_y = 4'd7;
        pt_valid = 1'b1;
        wait_edge();
        clr = 1'b0;
        pt_valid = 1'b0;
        check("clr_load_ready", {7'd0, pt_ready},  8'd1);
        check("clr_load_valid", {7'd0, res_valid}, 8'd0);
        run_frame({4'd1, 4'd2, 4'd3, 4'd4}, {4'd1, 4'd2, 4'd3, 4'd4}, 4'b0100, 1'b0);

        // clr mid-COMPARE: no result may appear; kendall clears.
        send_pts({4'd1, 4'd2, 4'd3, 4'd4}, {4'd4, 4'd3, 4'd2, 4'd1});
        wait_edge();
        wait_edge();
        check("mid_cmp_busy", {7'd0, busy}, 8'd1);
        clr = 1'b1;
        wait_edge();
        clr = 1'b0;
        check("clr_cmp_busy",    {7'd0, busy},      8'd0);
        check("clr_cmp_ready",   {7'd0, pt_ready},  8'd1);
        check("clr_cmp_kendall", {4'd0, kendall},   8'd0);
        for (int k = 0; k < 8; k++) begin
            wait_edge();
            if (res_valid) check("clr_cmp_no_result", 8'd1, 8'd0);
        end
        run_frame({4'd1, 4'd2, 4'd3, 4'd4}, {4'd1, 4'd2, 4'd3, 4'd4}, 4'b0100, 1'b0);

        // Asynchronous reset in the middle of a DONE cycle.
        res_ready = 1'b0;
        send_pts({4'd1, 4'd2, 4'd3, 4'd4}, {4'd2, 4'd1, 4'd4, 4'd3});
        for (int k = 0; k < 6; k++) wait_edge();
        check("pre_rst_valid",   {7'd0, res_valid}, 8'd1);
        check("pre_rst_kendall", {4'd0, kendall},   {4'd0, 4'b0001});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid",   {7'd0, res_valid}, 8'd0);
        check("async_rst_kendall", {4'd0, kendall},   8'd0);
        check("async_rst_busy",    {7'd0, busy},      8'd0);
        check("async_rst_ready",   {7'd0, pt_ready},  8'd1);
        #3;
        rst_n = 1'b1;
        res_ready = 1'b1;
        wait_edge();
        run_frame({4'd1, 4'd2, 4'd3, 4'd4}, {4'd4, 4'd3, 4'd1, 4'd2}, 4'b1101, 1'b1);

        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 50) begin
                wait_edge();
                n++;
            end
        end
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
